// File: rtl/zap_ifetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// No logic, no latency; used by the top and its FIFO entry format.
package zap_ifetch_responder_pkg;

  typedef enum logic [1:0] {
    IFR_IDLE    = 2'd0,
    IFR_REQ     = 2'd1,
    IFR_DISCARD = 2'd2,
    IFR_SLEEP   = 2'd3
  } ifr_state_t;

  localparam logic [31:0] ABORT_PAYLOAD = 32'd0;
  localparam logic [3:0]  WB_SEL_WORD   = 4'hF;

  // 65-bit FIFO entry: {abort, pc, instr}
  typedef struct packed {
    logic        abort;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifr_entry_t;

endpackage

// File: rtl/zap_ifetch_fifo.sv
// Synchronous FIFO with flush; head is combinational, push-to-head latency 1 cycle.
// Pop while empty is ignored; push while full is dropped unless a pop frees a slot.
module zap_ifetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign o_empty = (count == '0);
  assign o_full  = (count == (AW+1)'(DEPTH));
  assign o_head  = mem[rd_ptr];
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_flush) mem[wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/zap_ifetch_responder.sv
// Fetch responder: Wishbone classic reads into a FIFO; ack in cycle M -> o_valid in M+1, one word per 2 cycles max.
// Requests stall while the FIFO is full; optional bus watchdog under ZAP_IFETCH_TIMEOUT_EN.
module zap_ifetch_responder
  import zap_ifetch_responder_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'd0,
  parameter int          FIFO_DEPTH     = 2,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_rd_en,
  output logic [31:0] o_instruction,
  output logic        o_valid,
  output logic        o_instr_abort,
  output logic [31:0] o_pc,
  output logic        o_code_stall,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err
);

  ifr_state_t  state, state_n;
  logic [31:0] next_pc, next_pc_n, adr, adr_n, redir_pc;
  logic        cyc, cyc_n;
  logic        busy, resp, tmo_hit;
  logic        fifo_push, fifo_flush, fifo_pop, fifo_full, fifo_empty;
  ifr_entry_t  push_ent, head;

  assign redir_pc = i_redirect_pc & ~32'd3;
  assign busy     = (state == IFR_REQ) || (state == IFR_DISCARD);
  assign resp     = busy && (i_wb_ack || i_wb_err || tmo_hit);

`ifdef ZAP_IFETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = busy && !i_wb_ack && !i_wb_err && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Restarts for every new outstanding cycle, including re-entry into DISCARD.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                         tmo_cnt <= '0;
    else if (busy && !resp && !i_redirect)  tmo_cnt <= tmo_cnt + TW'(1);
    else                                    tmo_cnt <= '0;
  end
`else
  assign tmo_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IFR_IDLE;
      next_pc <= RESET_PC;
      adr     <= '0;
      cyc     <= 1'b0;
    end else begin
      state   <= state_n;
      next_pc <= next_pc_n;
      adr     <= adr_n;
      cyc     <= cyc_n;
    end
  end

  always_comb begin
    state_n    = state;
    next_pc_n  = next_pc;
    adr_n      = adr;
    cyc_n      = cyc;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    push_ent   = '0;
    if (i_redirect) begin
      fifo_flush = 1'b1;
      next_pc_n  = redir_pc;
      if (busy && !resp) begin
        state_n = IFR_DISCARD;
      end else begin
        // Bus is free this cycle, so the new fetch goes out immediately.
        state_n = IFR_REQ;
        cyc_n   = 1'b1;
        adr_n   = redir_pc;
      end
    end else begin
      case (state)
        IFR_IDLE: if (!fifo_full) begin
          state_n = IFR_REQ;
          cyc_n   = 1'b1;
          adr_n   = next_pc;
        end
        IFR_REQ: if (i_wb_err || tmo_hit) begin
          fifo_push = 1'b1;
          push_ent  = '{abort: 1'b1, pc: adr, instr: ABORT_PAYLOAD};
          cyc_n     = 1'b0;
          state_n   = IFR_SLEEP;
        end else if (i_wb_ack) begin
          fifo_push = 1'b1;
          push_ent  = '{abort: 1'b0, pc: adr, instr: i_wb_dat};
          next_pc_n = adr + 32'd4;
          cyc_n     = 1'b0;
          state_n   = IFR_IDLE;
        end
        IFR_DISCARD: if (resp) begin
          state_n = IFR_REQ;
          cyc_n   = 1'b1;
          adr_n   = next_pc;
        end
        default: ;
      endcase
    end
  end

  assign fifo_pop = i_rd_en && !fifo_empty;

  zap_ifetch_fifo #(
    .WIDTH ($bits(ifr_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_flush    (fifo_flush),
    .i_push     (fifo_push),
    .i_push_dat (push_ent),
    .i_pop      (fifo_pop),
    .o_full     (fifo_full),
    .o_empty    (fifo_empty),
    .o_head     (head)
  );

  assign o_valid       = !fifo_empty;
  assign o_code_stall  = fifo_empty;
  assign o_instruction = o_valid ? head.instr : 32'd0;
  assign o_pc          = o_valid ? head.pc : 32'd0;
  assign o_instr_abort = o_valid && head.abort;
  assign o_wb_cyc      = cyc;
  assign o_wb_stb      = cyc;
  assign o_wb_adr      = adr;
  assign o_wb_sel      = WB_SEL_WORD;

endmodule

// File: tb/tb_zap_ifetch_responder.sv
// Bench for zap_ifetch_responder: directed steps then random traffic against a queue model.
module tb_zap_ifetch_responder;

  localparam int TMO = 8;

  typedef struct packed {
    logic        abort;
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        i_clk, i_reset_n, i_redirect, i_rd_en, i_wb_ack, i_wb_err;
  logic [31:0] i_redirect_pc, i_wb_dat;
  logic [31:0] o_instruction, o_pc, o_wb_adr;
  logic        o_valid, o_instr_abort, o_code_stall, o_wb_cyc, o_wb_stb;
  logic [3:0]  o_wb_sel;

  zap_ifetch_responder #(
    .RESET_PC       (32'd0),
    .FIFO_DEPTH     (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_rd_en       (i_rd_en),
    .o_instruction (o_instruction),
    .o_valid       (o_valid),
    .o_instr_abort (o_instr_abort),
    .o_pc          (o_pc),
    .o_code_stall  (o_code_stall),
    .o_wb_cyc      (o_wb_cyc),
    .o_wb_stb      (o_wb_stb),
    .o_wb_adr      (o_wb_adr),
    .o_wb_sel      (o_wb_sel),
    .i_wb_dat      (i_wb_dat),
    .i_wb_ack      (i_wb_ack),
    .i_wb_err      (i_wb_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          tests = 0;
  int          fails = 0;
  ent_t        q[$];
  logic [31:0] expect_adr;
  bit          discarding, sleeping;
  int          run;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    expect_adr = 32'd0;
    discarding = 0;
    sleeping   = 0;
    run        = 0;
  endtask

  task automatic check_outputs();
    chk("valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
    chk("code_stall", {31'd0, o_code_stall}, {31'd0, q.size() == 0});
    if (q.size() != 0) begin
      chk("head_pc", o_pc, q[0].pc);
      chk("head_instr", o_instruction, q[0].instr);
      chk("head_abort", {31'd0, o_instr_abort}, {31'd0, q[0].abort});
    end
    chk("stb_eq_cyc", {31'd0, o_wb_stb}, {31'd0, o_wb_cyc});
    if (o_wb_cyc && !discarding) begin
      chk("wb_adr", o_wb_adr, expect_adr);
      chk("wb_sel", {28'd0, o_wb_sel}, 32'hF);
      chk("no_fetch_when_full", {31'd0, q.size() >= 2}, 32'd0);
    end
    if (discarding) chk("discard_holds_cyc", {31'd0, o_wb_cyc}, 32'd1);
    if (sleeping)   chk("sleep_no_cyc", {31'd0, o_wb_cyc}, 32'd0);
  endtask

  // One clock: check at the falling edge, drive inputs, advance the model to the next rising edge.
  task automatic step(input logic rd, input logic redir, input logic [31:0] rpc,
                      input logic ack_w, input logic err_w);
    logic cyc_s, a, e, tmo, done;
    @(negedge i_clk);
    check_outputs();
    cyc_s = o_wb_cyc;
    a = cyc_s && ack_w;
    e = cyc_s && err_w;
    i_rd_en       = rd;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_wb_ack      = a;
    i_wb_err      = e;
    i_wb_dat      = mem_word(o_wb_adr);
`ifdef ZAP_IFETCH_TIMEOUT_EN
    tmo = cyc_s && !a && !e && (run == TMO - 1);
`else
    tmo = 1'b0;
`endif
    done = cyc_s && (a || e || tmo);
    if (rd && q.size() != 0) void'(q.pop_front());
    if (redir) begin
      q.delete();
      expect_adr = {rpc[31:2], 2'b00};
      discarding = cyc_s && !done;
      sleeping   = 0;
    end else if (done) begin
      if (discarding) discarding = 0;
      else if (e || tmo) begin
        q.push_back('{abort: 1'b1, pc: expect_adr, instr: 32'd0});
        sleeping = 1;
      end else begin
        q.push_back('{abort: 1'b0, pc: expect_adr, instr: mem_word(expect_adr)});
        expect_adr = expect_adr + 32'd4;
      end
    end
    run = (cyc_s && !done && !redir) ? run + 1 : 0;
  endtask

  task automatic wait_cyc();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
      @(posedge i_clk);
      #1;
      seen = o_wb_cyc;
    end
    chk("wait_cyc", {31'd0, o_wb_cyc}, 32'd1);
  endtask

  initial begin
    i_reset_n = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'd0; i_rd_en = 1'b0;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = 32'd0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_abort", {31'd0, o_instr_abort}, 32'd0);
    chk("rst_instr", o_instruction, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
    chk("rst_adr", o_wb_adr, 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Consumer stalled: exactly two words captured, then the bus goes quiet.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    @(posedge i_clk); #1;
    chk("full_no_cyc", {31'd0, o_wb_cyc}, 32'd0);
    chk("full_head_pc", o_pc, 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);

    // Redirect while a read is outstanding: response dropped, fetch restarts at 0x1000.
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0);
    wait_cyc();
    step(1'b1, 1'b1, 32'h1003, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);

    // Redirect coincident with ack.
    wait_cyc();
    step(1'b1, 1'b1, 32'h2000, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);

    // Bus error: abort entry, then sleep until the next redirect.
    step(1'b1, 1'b1, 32'h20, 1'b1, 1'b0);
    wait_cyc();
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    @(posedge i_clk); #1;
    chk("err_abort", {31'd0, o_instr_abort}, 32'd1);
    chk("err_pc", o_pc, 32'h20);
    chk("err_instr", o_instruction, 32'd0);
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0);
    wait_cyc();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);

`ifdef ZAP_IFETCH_TIMEOUT_EN
    step(1'b1, 1'b1, 32'h80, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge i_clk); #1;
    chk("tmo_cyc_low", {31'd0, o_wb_cyc}, 32'd0);
    chk("tmo_abort", {31'd0, o_instr_abort}, 32'd1);
    chk("tmo_pc", o_pc, 32'h80);
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a read.
    wait_cyc();
    i_reset_n = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_redirect = 1'b0;
    #1;
    chk("arst_cyc", {31'd0, o_wb_cyc}, 32'd0);
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_adr", o_wb_adr, 32'd0);
    model_reset();
    @(negedge i_clk);
    i_wb_ack = 1'b1;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);

    // Random traffic, including redirects near the top of the address space.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, rpc,
           $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
